// File: rtl/res_packer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : res_packer_if
// Brief    : Packed-word valid/ready stream carrying a 16-bit word and its
//            10-bit word index from the result packer to its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface res_packer_if;
   logic        pk_valid;
   logic        pk_ready;
   logic [9:0]  pk_addr;
   logic [15:0] pk_data;

   // Producer side (packer)
   modport master (output pk_valid, output pk_addr, output pk_data, input pk_ready);
   // Consumer side (store / dump)
   modport slave  (input pk_valid, input pk_addr, input pk_data, output pk_ready);
endinterface
`default_nettype wire

// File: rtl/res_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : res_packer
// Brief    : Reads the 128x128 8-bit result image out of the result RAM,
//            thresholds each pixel to one bit, packs 16 pixels per word
//            (pixel 0 of a word in the MSB) and streams the words out.
//            Also accumulates the frame's nonzero-pixel count and max value.
// Revision : 1.0 - initial release
// ============================================================================
module res_packer #(
   parameter int         NWORDS = 1024,
   parameter logic [7:0] THRESH = 8'd0
) (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        start,
   output logic             busy,
   output logic             done,
   output logic             res_rd,
   output logic [13:0]      res_addr,
   input  wire logic [7:0]  res_di,
   res_packer_if.master     pk,
   output logic [14:0]      nz_cnt,
   output logic [7:0]       max_val
);

   localparam logic [9:0] c_LAST_W = 10'(NWORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_OUT  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [9:0]  r_w, w_w_nxt;            // word counter
   logic [3:0]  r_j, w_j_nxt;            // pixel-within-word counter
   logic [14:0] r_sh, w_sh_nxt;          // pixels collected so far, oldest in MSB
   logic        r_busy, w_busy_nxt;
   logic        r_done, w_done_nxt;
   logic        r_rd, w_rd_nxt;
   logic [13:0] r_addr, w_addr_nxt;
   logic        r_valid, w_valid_nxt;
   logic [9:0]  r_pk_addr, w_pk_addr_nxt;
   logic [15:0] r_pk_data, w_pk_data_nxt;
   logic [14:0] r_nz, w_nz_nxt;
   logic [7:0]  r_max, w_max_nxt;

   // Pixel sampled at the end of the current RD cycle (RAM drove it at negedge)
   logic        w_bit;
   logic [15:0] w_word;
   assign w_bit  = (res_di > THRESH);
   assign w_word = {r_sh, w_bit};

   // Next-state and next-output decode; every output is then registered
   always_comb begin
      w_state_nxt   = r_state;
      w_w_nxt       = r_w;
      w_j_nxt       = r_j;
      w_sh_nxt      = r_sh;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_rd_nxt      = 1'b0;
      w_addr_nxt    = r_addr;
      w_valid_nxt   = r_valid;
      w_pk_addr_nxt = r_pk_addr;
      w_pk_data_nxt = r_pk_data;
      w_nz_nxt      = r_nz;
      w_max_nxt     = r_max;

      case (r_state)
         S_IDLE: begin
            w_busy_nxt = 1'b0;
            if (start) begin
               w_state_nxt = S_RD;
               w_busy_nxt  = 1'b1;
               w_w_nxt     = 10'd0;
               w_j_nxt     = 4'd0;
               w_nz_nxt    = 15'd0;
               w_max_nxt   = 8'd0;
               w_rd_nxt    = 1'b1;
               w_addr_nxt  = 14'd0;
            end
         end

         S_RD: begin
            w_sh_nxt  = w_word[14:0];
            w_nz_nxt  = r_nz + 15'(w_bit);
            w_max_nxt = (res_di > r_max) ? res_di : r_max;
            if (r_j == 4'd15) begin
               // Word complete: present it; reads pause until it is taken
               w_state_nxt   = S_OUT;
               w_valid_nxt   = 1'b1;
               w_pk_addr_nxt = r_w;
               w_pk_data_nxt = w_word;
            end else begin
               w_j_nxt    = r_j + 4'd1;
               w_rd_nxt   = 1'b1;
               w_addr_nxt = {r_w, r_j + 4'd1};
            end
         end

         S_OUT: begin
            if (pk.pk_ready) begin
               w_valid_nxt = 1'b0;
               if (r_w == c_LAST_W) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_RD;
                  w_w_nxt     = r_w + 10'd1;
                  w_j_nxt     = 4'd0;
                  w_rd_nxt    = 1'b1;
                  w_addr_nxt  = {r_w + 10'd1, 4'd0};
               end
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any frame in progress
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_w       <= 10'd0;
         r_j       <= 4'd0;
         r_sh      <= 15'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rd      <= 1'b0;
         r_addr    <= 14'd0;
         r_valid   <= 1'b0;
         r_pk_addr <= 10'd0;
         r_pk_data <= 16'd0;
         r_nz      <= 15'd0;
         r_max     <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_w       <= w_w_nxt;
         r_j       <= w_j_nxt;
         r_sh      <= w_sh_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_rd      <= w_rd_nxt;
         r_addr    <= w_addr_nxt;
         r_valid   <= w_valid_nxt;
         r_pk_addr <= w_pk_addr_nxt;
         r_pk_data <= w_pk_data_nxt;
         r_nz      <= w_nz_nxt;
         r_max     <= w_max_nxt;
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign res_rd      = r_rd;
   assign res_addr    = r_addr;
   assign pk.pk_valid = r_valid;
   assign pk.pk_addr  = r_pk_addr;
   assign pk.pk_data  = r_pk_data;
   assign nz_cnt      = r_nz;
   assign max_val     = r_max;

endmodule
`default_nettype wire

// File: tb/tb_res_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_res_packer
// Brief    : Self-checking bench for res_packer: full-frame DUT (THRESH=0)
//            with a result-RAM model and word scoreboard, plus a two-word
//            DUT (THRESH=2) for threshold boundary behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_res_packer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, start2;
   logic        busy, done, res_rd;
   logic [13:0] res_addr;
   logic [7:0]  res_di;
   logic [14:0] nz_cnt;
   logic [7:0]  max_val;
   logic        busy2, done2, res_rd2;
   logic [13:0] res_addr2;
   logic [7:0]  res_di2;
   logic [14:0] nz_cnt2;
   logic [7:0]  max_val2;

   res_packer_if pk_if ();
   res_packer_if pk2_if ();

   res_packer #(.NWORDS(1024), .THRESH(8'd0)) u_dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di), .pk(pk_if),
      .nz_cnt(nz_cnt), .max_val(max_val));

   res_packer #(.NWORDS(2), .THRESH(8'd2)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
      .res_rd(res_rd2), .res_addr(res_addr2), .res_di(res_di2), .pk(pk2_if),
      .nz_cnt(nz_cnt2), .max_val(max_val2));

   logic [7:0]  mem  [0:16383];
   logic [7:0]  mem2 [0:31];
   logic [15:0] cap  [0:1023];
   logic [15:0] cap2 [0:1];

   int n_vec = 0;
   int n_err = 0;
   int n_words = 0;
   int n_done = 0;
   int n_overlap = 0;
   int n_w2 = 0;

   typedef struct { logic [9:0] a; logic [15:0] d; } exp_t;
   exp_t sbq[$];

   typedef struct { int w; logic [15:0] d; } vec_t;
   vec_t vb [6];
   vec_t v2 [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // Reference packing: pixel j of word w goes to bit 15-j, set when nonzero
   function automatic logic [15:0] model_word(input int w);
      logic [15:0] r;
      for (int j = 0; j < 16; j++) r[15-j] = (mem[w*16+j] != 8'd0);
      return r;
   endfunction

   task automatic push_frame();
      sbq.delete();
      for (int w = 0; w < 1024; w++) sbq.push_back('{a: 10'(w), d: model_word(w)});
   endtask

   // Result RAM models: data appears at the negedge of a read cycle
   always @(negedge clk) if (res_rd)  res_di  <= mem[res_addr];
   always @(negedge clk) if (res_rd2) res_di2 <= mem2[res_addr2[4:0]];

   // Scoreboard and protocol monitors for the full-frame DUT
   always @(negedge clk) begin
      if (reset && pk_if.pk_valid && pk_if.pk_ready) begin
         if (sbq.size() == 0) chk("sb_unexpected_word", 32'(pk_if.pk_addr), 32'hFFFF_FFFF);
         else begin
            chk("sb_pk_addr", 32'(pk_if.pk_addr), 32'(sbq[0].a));
            chk("sb_pk_data", 32'(pk_if.pk_data), 32'(sbq[0].d));
            void'(sbq.pop_front());
         end
         cap[pk_if.pk_addr] <= pk_if.pk_data;
         n_words <= n_words + 1;
      end
      if (done) n_done <= n_done + 1;
      if (pk_if.pk_valid && res_rd) n_overlap <= n_overlap + 1;
   end

   // Capture for the two-word DUT
   always @(negedge clk) begin
      if (reset && pk2_if.pk_valid && pk2_if.pk_ready) begin
         chk("d2_pk_addr", 32'(pk2_if.pk_addr), 32'(n_w2));
         cap2[pk2_if.pk_addr[0]] <= pk2_if.pk_data;
         n_w2 <= n_w2 + 1;
      end
   end

   initial begin
      int cyc, base_w, base_d, base_ov;
      bit hit;
      reset = 1'b0; start = 1'b0; start2 = 1'b0;
      pk_if.pk_ready = 1'b1; pk2_if.pk_ready = 1'b1;
      for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
      for (int i = 0; i < 32; i++) mem2[i] = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", {busy, done, res_rd, pk_if.pk_valid}, 0);
      chk("rst_addr", {res_addr, pk_if.pk_addr}, 0);
      chk("rst_data", 32'(pk_if.pk_data), 0);
      chk("rst_stats", {nz_cnt, max_val}, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Two-word DUT, THRESH=2: 1,2,3,4 -> 0011..., equal-to-threshold is 0
      mem2[0] = 8'd1; mem2[1] = 8'd2; mem2[2] = 8'd3; mem2[3] = 8'd4;
      mem2[20] = 8'd3; mem2[31] = 8'd2;
      v2[0] = '{w: 0, d: 16'h3000};
      v2[1] = '{w: 1, d: 16'h0800};
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      cyc = 1;
      while (!done2 && cyc < 200) begin @(posedge clk); #1; cyc++; end
      chk("d2_done_cycle", cyc, 35);
      for (int i = 0; i < 2; i++) chk("d2_word", 32'(cap2[v2[i].w]), 32'(v2[i].d));
      chk("d2_nz_cnt", 32'(nz_cnt2), 3);
      chk("d2_max_val", 32'(max_val2), 4);

      // Frame A: all-zero RAM, ready high, exact done timing
      push_frame();
      base_w = n_words; base_d = n_done; base_ov = n_overlap;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      chk("a_first_cycle", {busy, res_rd, res_addr}, {1'b1, 1'b1, 14'd0});
      while (!done && cyc < 20000) begin @(posedge clk); #1; cyc++; end
      chk("a_done_cycle", cyc, 17409);
      chk("a_busy_at_done", busy, 1);
      @(posedge clk); #1;
      chk("a_after_done", {done, busy}, 0);
      chk("a_words", n_words - base_w, 1024);
      chk("a_sb_left", sbq.size(), 0);
      chk("a_done_pulses", n_done - base_d, 1);
      chk("a_stats", {nz_cnt, max_val}, 0);

      // Frame B: patterned RAM, 5-cycle stall on word 1, stray start in word 10
      mem[0] = 8'h01; mem[16383] = 8'h05;
      for (int i = 16; i < 32; i++) mem[i] = 8'hFF;
      vb[0] = '{w: 0,    d: 16'h8000};
      vb[1] = '{w: 1,    d: 16'hFFFF};
      vb[2] = '{w: 2,    d: 16'h0000};
      vb[3] = '{w: 10,   d: 16'h0000};
      vb[4] = '{w: 1022, d: 16'h0000};
      vb[5] = '{w: 1023, d: 16'h0001};
      push_frame();
      base_w = n_words; base_d = n_done;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      fork
         begin : wait_done
            int c;
            c = 1;
            while (!done && c < 21000) begin @(posedge clk); #1; c++; end
            chk("b_done_cycle", c, 17414);
         end
         begin : stall_and_poke
            hit = 1'b0;
            for (int k = 0; k < 100 && !hit; k++) begin
               if (pk_if.pk_valid && pk_if.pk_addr == 10'd1) hit = 1'b1;
               else begin @(posedge clk); #1; end
            end
            chk("b_word1_seen", hit, 1);
            pk_if.pk_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(posedge clk); #1;
               chk("b_stall_valid", pk_if.pk_valid, 1);
               chk("b_stall_data", 32'(pk_if.pk_data), 32'hFFFF);
               chk("b_stall_addr", 32'(pk_if.pk_addr), 1);
               chk("b_stall_rd", res_rd, 0);
            end
            pk_if.pk_ready = 1'b1;
            @(posedge clk); #1;
            chk("b_resume", {pk_if.pk_valid, res_rd, res_addr}, {1'b0, 1'b1, 14'd32});
            hit = 1'b0;
            for (int k = 0; k < 400 && !hit; k++) begin
               if (res_rd && res_addr == 14'd163) hit = 1'b1;
               else begin @(posedge clk); #1; end
            end
            chk("b_word10_seen", hit, 1);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("b_start_ignored", {busy, res_addr}, {1'b1, 14'd164});
         end
      join
      @(posedge clk); #1;
      chk("b_after_done", {done, busy}, 0);
      chk("b_words", n_words - base_w, 1024);
      chk("b_sb_left", sbq.size(), 0);
      chk("b_done_pulses", n_done - base_d, 1);
      chk("b_nz_cnt", 32'(nz_cnt), 18);
      chk("b_max_val", 32'(max_val), 32'hFF);
      for (int i = 0; i < 6; i++) chk("b_table_word", 32'(cap[vb[i].w]), 32'(vb[i].d));
      chk("ab_rd_during_out", n_overlap - base_ov, 0);

      // Frame C: reset during RD of word 500
      push_frame();
      base_d = n_done;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 9000 && !hit; k++) begin
         if (res_rd && res_addr == 14'(500*16+5)) hit = 1'b1;
         else begin @(posedge clk); #1; end
      end
      chk("c_word500_seen", hit, 1);
      chk("c_nz_before_rst", 32'(nz_cnt), 17);
      reset = 1'b0;
      #1;
      chk("c_async_ctrl", {busy, done, res_rd, pk_if.pk_valid}, 0);
      chk("c_async_addr", {res_addr, pk_if.pk_addr}, 0);
      chk("c_async_data", 32'(pk_if.pk_data), 0);
      chk("c_async_stats", {nz_cnt, max_val}, 0);
      sbq.delete();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("c_idle_after_rst", {pk_if.pk_valid, busy, done, res_rd}, 0);
      end
      chk("c_no_partial_done", n_done - base_d, 0);

      // Frame D: fresh start repacks from word 0 with cleared statistics
      push_frame();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!pk_if.pk_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
      chk("d_first_word_cycle", cyc, 17);
      chk("d_first_word", {pk_if.pk_addr, pk_if.pk_data}, {10'd0, 16'h8000});
      chk("d_stats", {nz_cnt, max_val}, {15'd1, 8'd1});
      @(posedge clk); #1;
      reset = 1'b0;
      sbq.delete();
      #2;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
